cpu_controller: RTL
===================

Name: cpu_controller

Overview:
- Eight-phase instruction sequencer for the 8-bit accumulator CPU.
- Drives the control strobes of the datapath, including rd/wr of the shared 32x8 memory and tri-state enable of the accumulator bus driver.
- Sits directly upstream of the memory: its rd/wr/sel outputs determine when memory drives or samples the bidirectional data bus and whether the address comes from the PC (sel=1) or the IR operand field (sel=0).

Parameters:
- OPCODE_W, 3, opcode width; only 3 is supported.
- HALT_STICKY, 1. When 1, HLT freezes the sequencer until reset. When 0, halt pulses for one cycle and execution continues.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  OPCODE_W  opcode field from the instruction register.
- zero  input  1  accumulator-is-zero flag.
- sel  output  1  address mux select: 1=PC, 0=IR operand.
- rd  output  1  memory read enable (memory drives bus).
- wr  output  1  memory write enable (sampled by memory at posedge).
- ld_ir  output  1  load instruction register.
- ld_ac  output  1  load accumulator.
- ld_pc  output  1  load PC from IR operand (jump).
- inc_pc  output  1  increment PC.
- data_e  output  1  enable accumulator driver onto data bus.
- halt  output  1  CPU halted.
- phase  output  3  current phase, for debug/verification.

Behaviour:
- Opcodes, in package: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7. ALUOP = ADD|AND|XOR|LDA.
- Phases, in order: INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3, OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7.
- Phase register: 3-bit, advances by 1 every clk, wraps 7->0. One instruction takes exactly 8 cycles.
- Reset: phase=INST_ADDR, halted flag=0. During reset and in the cycle after release, outputs are the INST_ADDR decode: sel=1, all others 0.
- Outputs are combinational decode of (phase, opcode, zero, halted) only; no other logic.
- opcode and zero are don't-care in phases 0-3. The IR is loaded during phases 2-3, so opcode is valid from phase 4.
- Decode by phase:
  - INST_ADDR: sel=1.
  - INST_FETCH: sel=1, rd=1.
  - INST_LOAD: sel=1, rd=1, ld_ir=1.
  - IDLE: sel=1, rd=1, ld_ir=1.
  - OP_ADDR: inc_pc = (opcode!=HLT); halt = (opcode==HLT).
  - OP_FETCH: rd=ALUOP.
  - ALU_OP: rd=ALUOP; inc_pc = (opcode==SKZ && zero); ld_pc=JMP; data_e=STO.
  - STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=JMP; wr=STO; data_e=STO.
- Bus safety: rd and wr are never both 1 in any phase. data_e is high in ALU_OP, the cycle before wr, so the bus is settled at the write edge.
- Sticky halt (HALT_STICKY=1):
  - At the posedge ending OP_ADDR with opcode==HLT, the halted flag sets and phase holds at OP_ADDR.
  - While halted: halt=1, all other strobes 0, phase frozen.
  - Only rst clears the halted flag.
- Non-sticky halt (HALT_STICKY=0): halt is high for the OP_ADDR cycle only, the PC is not incremented, and phase continues.
- Reset mid-instruction, including during STORE: wr drops asynchronously with rst; no partial write is retried; restart at INST_ADDR.
- An undefined opcode cannot occur, since all 8 values are decoded.

Decomposition:
- veririsc_pkg holds:
  - opcode localparams HLT..JMP;
  - phase localparams INST_ADDR..STORE;
  - PHASE_W=3;
  - an is_aluop function.
- One combinational sub-module, ctrl_decode, maps (phase, opcode, zero, halted) to the strobe vector.
- cpu_controller holds the phase counter, the halted flag and the parameter handling.

Test Plan:
- Reset, release, opcode=ADD, zero=0, run 8 cycles -> phase 0..7. Strobes high per phase:
  - phase 4: inc_pc;
  - phase 5: rd;
  - phase 6: rd;
  - phase 7: rd, ld_ac.
  - wr=0 throughout; phase 0 follows.
- opcode=STO -> data_e=1 in phases 6-7; wr=1 only in phase 7; rd=0 in phases 5-7; memory word written once.
- opcode=SKZ: zero=1 -> inc_pc=1 in phases 4 and 6. zero=0 -> inc_pc=1 in phase 4 only.
- opcode=JMP -> ld_pc=1 in phases 6 and 7; inc_pc=1 in phase 4; ld_ac=0.
- opcode=HLT, HALT_STICKY=1 -> halt=1 from phase 4 onward; phase stuck at 4 for 20 cycles with all strobes 0. Assert rst -> phase=0, halt=0.
- rst asserted asynchronously mid-phase 7 with STO -> wr and data_e fall immediately, with no clock edge needed; after release, phase=0 with sel=1.

Source files
------------

// File: rtl/veririsc_pkg.sv
// Shared opcode/phase encodings and control-strobe payload for the VeriRISC accumulator CPU.
package veririsc_pkg;

  localparam int unsigned PHASE_W = 3;
  localparam int unsigned OP_W    = 3;

  localparam logic [OP_W-1:0] HLT = 3'd0;
  localparam logic [OP_W-1:0] SKZ = 3'd1;
  localparam logic [OP_W-1:0] ADD = 3'd2;
  localparam logic [OP_W-1:0] AND = 3'd3;
  localparam logic [OP_W-1:0] XOR = 3'd4;
  localparam logic [OP_W-1:0] LDA = 3'd5;
  localparam logic [OP_W-1:0] STO = 3'd6;
  localparam logic [OP_W-1:0] JMP = 3'd7;

  localparam logic [PHASE_W-1:0] INST_ADDR  = 3'd0;
  localparam logic [PHASE_W-1:0] INST_FETCH = 3'd1;
  localparam logic [PHASE_W-1:0] INST_LOAD  = 3'd2;
  localparam logic [PHASE_W-1:0] IDLE       = 3'd3;
  localparam logic [PHASE_W-1:0] OP_ADDR    = 3'd4;
  localparam logic [PHASE_W-1:0] OP_FETCH   = 3'd5;
  localparam logic [PHASE_W-1:0] ALU_OP     = 3'd6;
  localparam logic [PHASE_W-1:0] STORE      = 3'd7;

  typedef struct packed {
    logic sel;
    logic rd;
    logic wr;
    logic ld_ir;
    logic ld_ac;
    logic ld_pc;
    logic inc_pc;
    logic data_e;
    logic halt;
  } ctrl_t;

  // Instructions that read an operand from memory and write the accumulator
  function automatic logic is_aluop(input logic [OP_W-1:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/cpu_controller_ctrl_decode.sv
// Pure combinational decode of (phase, opcode, zero, halted) into datapath strobes.
module ctrl_decode
  import veririsc_pkg::*;
(
  input  logic [PHASE_W-1:0] i_phase,
  input  logic [OP_W-1:0]    i_opcode,
  input  logic               i_zero,
  input  logic               i_halted,
  output ctrl_t              o_ctrl
);

  logic w_aluop;
  assign w_aluop = is_aluop(i_opcode);

  always_comb begin
    o_ctrl = '0;
    if (i_halted) begin
      o_ctrl.halt = 1'b1;
    end else begin
      case (i_phase)
        INST_ADDR: begin
          o_ctrl.sel = 1'b1;
        end
        INST_FETCH: begin
          o_ctrl.sel = 1'b1;
          o_ctrl.rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          o_ctrl.sel   = 1'b1;
          o_ctrl.rd    = 1'b1;
          o_ctrl.ld_ir = 1'b1;
        end
        OP_ADDR: begin
          o_ctrl.inc_pc = (i_opcode != HLT);
          o_ctrl.halt   = (i_opcode == HLT);
        end
        OP_FETCH: begin
          o_ctrl.rd = w_aluop;
        end
        // data_e leads wr by one cycle so the bus is settled at the write edge
        ALU_OP: begin
          o_ctrl.rd     = w_aluop;
          o_ctrl.inc_pc = (i_opcode == SKZ) && i_zero;
          o_ctrl.ld_pc  = (i_opcode == JMP);
          o_ctrl.data_e = (i_opcode == STO);
        end
        STORE: begin
          o_ctrl.rd     = w_aluop;
          o_ctrl.ld_ac  = w_aluop;
          o_ctrl.ld_pc  = (i_opcode == JMP);
          o_ctrl.wr     = (i_opcode == STO);
          o_ctrl.data_e = (i_opcode == STO);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer: phase counter, halt flag and strobe decode.
module cpu_controller
  import veririsc_pkg::*;
#(
  parameter int unsigned OPCODE_W    = 3,
  parameter int unsigned HALT_STICKY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  output logic                sel,
  output logic                rd,
  output logic                wr,
  output logic                ld_ir,
  output logic                ld_ac,
  output logic                ld_pc,
  output logic                inc_pc,
  output logic                data_e,
  output logic                halt,
  output logic [PHASE_W-1:0]  phase
);

  localparam bit STICKY = (HALT_STICKY != 0);

  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] w_phase_nxt;
  logic               r_halted;
  logic               w_halted_nxt;
  logic [OP_W-1:0]    w_opcode;
  ctrl_t              w_ctrl;

  assign w_opcode = OP_W'(opcode);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase  <= INST_ADDR;
      r_halted <= 1'b0;
    end else begin
      r_phase  <= w_phase_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  // A sticky HLT freezes the phase at OP_ADDR until reset
  always_comb begin
    w_halted_nxt = r_halted;
    w_phase_nxt  = r_phase + PHASE_W'(1);
    if (STICKY && !r_halted && (r_phase == OP_ADDR) && (w_opcode == HLT)) begin
      w_halted_nxt = 1'b1;
    end
    if (w_halted_nxt) begin
      w_phase_nxt = r_phase;
    end
  end

  ctrl_decode u_ctrl_decode (
    .i_phase  (r_phase),
    .i_opcode (w_opcode),
    .i_zero   (zero),
    .i_halted (r_halted),
    .o_ctrl   (w_ctrl)
  );

  assign sel    = w_ctrl.sel;
  assign rd     = w_ctrl.rd;
  assign wr     = w_ctrl.wr;
  assign ld_ir  = w_ctrl.ld_ir;
  assign ld_ac  = w_ctrl.ld_ac;
  assign ld_pc  = w_ctrl.ld_pc;
  assign inc_pc = w_ctrl.inc_pc;
  assign data_e = w_ctrl.data_e;
  assign halt   = w_ctrl.halt;
  assign phase  = r_phase;

endmodule
